// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: shared VGA timing defaults for 640x480@60.
//   - default horizontal/vertical visible, porch and sync lengths
//   - axis_total(): sums one axis into its period length
//   - H_TOTAL_DEF / V_TOTAL_DEF: default line and frame periods (800 / 525)
//   - coord_t: 10-bit pixel coordinate type used for DrawX/DrawY
package vga_timing_pkg;

  localparam int unsigned H_VISIBLE_DEF = 32'd640;
  localparam int unsigned H_FRONT_DEF   = 32'd16;
  localparam int unsigned H_SYNC_DEF    = 32'd96;
  localparam int unsigned H_BACK_DEF    = 32'd48;
  localparam int unsigned V_VISIBLE_DEF = 32'd480;
  localparam int unsigned V_FRONT_DEF   = 32'd10;
  localparam int unsigned V_SYNC_DEF    = 32'd2;
  localparam int unsigned V_BACK_DEF    = 32'd33;

  typedef logic [9:0] coord_t;

  function automatic int unsigned axis_total(
    input int unsigned visible,
    input int unsigned front,
    input int unsigned sync,
    input int unsigned back
  );
    return visible + front + sync + back;
  endfunction

  localparam int unsigned H_TOTAL_DEF =
    axis_total(H_VISIBLE_DEF, H_FRONT_DEF, H_SYNC_DEF, H_BACK_DEF);
  localparam int unsigned V_TOTAL_DEF =
    axis_total(V_VISIBLE_DEF, V_FRONT_DEF, V_SYNC_DEF, V_BACK_DEF);

endpackage

// File: rtl/vga_axis_counter.sv
// vga_axis_counter: one timing axis (horizontal or vertical).
// Ports:
//   clk     - pixel clock
//   rst     - asynchronous active-high reset (count=0, sync_n=1)
//   enable  - advance the counter this cycle
//   count   - current position, 0..TOTAL-1
//   wrap    - combinational: enable is high and count is at TOTAL-1
//   sync_n  - active-low sync, registered one clock behind count
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int unsigned TOTAL      = H_TOTAL_DEF,
  parameter int unsigned SYNC_START = H_VISIBLE_DEF + H_FRONT_DEF,
  parameter int unsigned SYNC_WIDTH = H_SYNC_DEF
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   enable,
  output coord_t count,
  output logic   wrap,
  output logic   sync_n
);

  localparam coord_t LAST       = coord_t'(TOTAL - 32'd1);
  localparam coord_t SYNC_FIRST = coord_t'(SYNC_START);
  localparam coord_t SYNC_LAST  = coord_t'(SYNC_START + SYNC_WIDTH - 32'd1);

  coord_t count_r;
  logic   sync_n_r;
  logic   at_end_s;
  logic   in_sync_s;

  // End-of-period and sync-window decode from the current count.
  always_comb begin
    at_end_s  = (count_r == LAST);
    in_sync_s = (count_r >= SYNC_FIRST) && (count_r <= SYNC_LAST);
    wrap      = enable && at_end_s;
  end

  // Position counter: advances when enabled, wraps TOTAL-1 -> 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_r <= 10'd0;
    end else if (enable) begin
      if (at_end_s) begin
        count_r <= 10'd0;
      end else begin
        count_r <= count_r + 10'd1;
      end
    end else begin
      count_r <= count_r;
    end
  end

  // Sync is sampled every clock (not only on enable) so it trails the
  // coordinate by exactly one pixel, lining up with registered RGB downstream.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_n_r <= 1'b1;
    end else begin
      sync_n_r <= ~in_sync_s;
    end
  end

  assign count  = count_r;
  assign sync_n = sync_n_r;

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA raster timing generator.
// Ports:
//   vga_clk     - pixel clock (only clock)
//   reset       - asynchronous active-high reset
//   DrawX/DrawY - current pixel column/row (direct from counters)
//   blank       - 1 while the pixel is inside the visible area
//   hs / vs     - active-low syncs, one clock behind DrawX/DrawY
//   frame_start - one-clock pulse at (0,0) when reached by frame wrap
//   frame_count - completed-frame counter; a live 8-bit counter only when
//                 macro VGA_FRAME_COUNT_EN is defined, otherwise constant 0
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_VISIBLE = H_VISIBLE_DEF,
  parameter int unsigned H_FRONT   = H_FRONT_DEF,
  parameter int unsigned H_SYNC    = H_SYNC_DEF,
  parameter int unsigned H_BACK    = H_BACK_DEF,
  parameter int unsigned V_VISIBLE = V_VISIBLE_DEF,
  parameter int unsigned V_FRONT   = V_FRONT_DEF,
  parameter int unsigned V_SYNC    = V_SYNC_DEF,
  parameter int unsigned V_BACK    = V_BACK_DEF
) (
  input  logic       vga_clk,
  input  logic       reset,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic       blank,
  output logic       hs,
  output logic       vs,
  output logic       frame_start,
  output logic [7:0] frame_count
);

  localparam int unsigned H_TOTAL = axis_total(H_VISIBLE, H_FRONT, H_SYNC, H_BACK);
  localparam int unsigned V_TOTAL = axis_total(V_VISIBLE, V_FRONT, V_SYNC, V_BACK);
  localparam coord_t H_VIS_C = coord_t'(H_VISIBLE);
  localparam coord_t V_VIS_C = coord_t'(V_VISIBLE);

  coord_t hc_s;
  coord_t vc_s;
  logic   h_wrap_s;
  logic   v_wrap_s;
  logic   frame_start_r;

  vga_axis_counter #(
    .TOTAL      (H_TOTAL),
    .SYNC_START (H_VISIBLE + H_FRONT),
    .SYNC_WIDTH (H_SYNC)
  ) u_h_axis (
    .clk    (vga_clk),
    .rst    (reset),
    .enable (1'b1),
    .count  (hc_s),
    .wrap   (h_wrap_s),
    .sync_n (hs)
  );

  // Vertical axis steps only on the cycle the line wraps.
  vga_axis_counter #(
    .TOTAL      (V_TOTAL),
    .SYNC_START (V_VISIBLE + V_FRONT),
    .SYNC_WIDTH (V_SYNC)
  ) u_v_axis (
    .clk    (vga_clk),
    .rst    (reset),
    .enable (h_wrap_s),
    .count  (vc_s),
    .wrap   (v_wrap_s),
    .sync_n (vs)
  );

  // Pulse is set on the edge that wraps the frame, so it is high exactly
  // while (0,0) is showing; the reset-entered (0,0) never sees it.
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      frame_start_r <= 1'b0;
    end else begin
      frame_start_r <= h_wrap_s && v_wrap_s;
    end
  end

`ifdef VGA_FRAME_COUNT_EN
  logic [7:0] frame_count_r;

  // Completed-frame counter, natural 8-bit wrap 255 -> 0.
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      frame_count_r <= 8'd0;
    end else if (frame_start_r) begin
      frame_count_r <= frame_count_r + 8'd1;
    end else begin
      frame_count_r <= frame_count_r;
    end
  end

  assign frame_count = frame_count_r;
`else
  assign frame_count = 8'd0;
`endif

  assign DrawX       = hc_s;
  assign DrawY       = vc_s;
  assign blank       = (hc_s < H_VIS_C) && (vc_s < V_VIS_C);
  assign frame_start = frame_start_r;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: directed self-checking bench for vga_timing_gen.
// dut_full uses the default 640x480 timing for line-level and async reset
// checks; dut_small uses a scaled 8x8-clock raster (hsync/vsync at 5..6,
// visible 4x4) so that frame-level behaviour, including 256 frames of
// frame_count, completes in a short run.
module tb_vga_timing_gen;

  logic       vga_clk;
  logic       rst_f;
  logic       rst_s;
  logic [9:0] dx_f, dy_f, dx_s, dy_s;
  logic       blank_f, hs_f, vs_f, fs_f;
  logic       blank_s, hs_s, vs_s, fs_s;
  logic [7:0] fc_f, fc_s;

  int tests = 0;
  int fails = 0;

`ifdef VGA_FRAME_COUNT_EN
  localparam bit FC_EN = 1'b1;
`else
  localparam bit FC_EN = 1'b0;
`endif

  vga_timing_gen dut_full (
    .vga_clk     (vga_clk),
    .reset       (rst_f),
    .DrawX       (dx_f),
    .DrawY       (dy_f),
    .blank       (blank_f),
    .hs          (hs_f),
    .vs          (vs_f),
    .frame_start (fs_f),
    .frame_count (fc_f)
  );

  vga_timing_gen #(
    .H_VISIBLE (4), .H_FRONT (1), .H_SYNC (2), .H_BACK (1),
    .V_VISIBLE (4), .V_FRONT (1), .V_SYNC (2), .V_BACK (1)
  ) dut_small (
    .vga_clk     (vga_clk),
    .reset       (rst_s),
    .DrawX       (dx_s),
    .DrawY       (dy_s),
    .blank       (blank_s),
    .hs          (hs_s),
    .vs          (vs_s),
    .frame_start (fs_s),
    .frame_count (fc_s)
  );

  initial vga_clk = 1'b0;
  always #5 vga_clk = ~vga_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    int hs_low;
    int hs_first;
    int vs_low;
    int vs_first;
    int pulses;

    rst_f = 1'b1;
    rst_s = 1'b1;
    repeat (2) @(negedge vga_clk);

    // Reset state
    check("rst_drawx", dx_f, 0);
    check("rst_drawy", dy_f, 0);
    check("rst_hs", hs_f, 1);
    check("rst_vs", vs_f, 1);
    check("rst_blank", blank_f, 1);
    check("rst_frame_start", fs_f, 0);
    check("rst_frame_count", fc_f, 0);

    // Release at a negedge: state (0,0); first posedge moves DrawX to 1.
    rst_f = 1'b0;
    rst_s = 1'b0;
    hs_low   = 0;
    hs_first = -1;
    for (int k = 0; k <= 800; k++) begin
      int pk;
      pk = k - 1;
      check("line_drawx", dx_f, k % 800);
      check("line_drawy", dy_f, k / 800);
      check("line_blank", blank_f, ((k % 800) < 640 && (k / 800) < 480) ? 1 : 0);
      check("line_hs", hs_f, (pk >= 656 && pk <= 751) ? 0 : 1);
      check("line_vs", vs_f, 1);
      if (k < 800) begin
        if (hs_f === 1'b0) begin
          hs_low++;
          if (hs_first < 0) hs_first = k;
        end
        @(negedge vga_clk);
      end
    end
    check("line_hs_low_count", hs_low, 96);
    check("line_hs_first_low", hs_first, 657);

    // Advance to (700,2), inside hsync and horizontal blanking.
    repeat (1500) @(negedge vga_clk);
    check("pre_rst_drawx", dx_f, 700);
    check("pre_rst_drawy", dy_f, 2);
    check("pre_rst_hs", hs_f, 0);
    check("pre_rst_blank", blank_f, 0);
    // Assert reset between edges; outputs must settle before next posedge.
    #2 rst_f = 1'b1;
    #1;
    check("async_rst_drawx", dx_f, 0);
    check("async_rst_drawy", dy_f, 0);
    check("async_rst_hs", hs_f, 1);
    check("async_rst_vs", vs_f, 1);
    check("async_rst_blank", blank_f, 1);
    @(negedge vga_clk);
    rst_f = 1'b0;

    // Small raster: restart it, then walk three frames cycle by cycle.
    rst_s = 1'b1;
    @(negedge vga_clk);
    rst_s = 1'b0;
    vs_low   = 0;
    vs_first = -1;
    pulses   = 0;
    for (int k = 0; k < 192; k++) begin
      int pk;
      int hp;
      int vp;
      pk = k - 1;
      hp = (pk < 0) ? -1 : pk % 8;
      vp = (pk < 0) ? -1 : (pk / 8) % 8;
      check("frm_drawx", dx_s, k % 8);
      check("frm_drawy", dy_s, (k / 8) % 8);
      check("frm_blank", blank_s, ((k % 8) < 4 && ((k / 8) % 8) < 4) ? 1 : 0);
      check("frm_hs", hs_s, (hp >= 5 && hp <= 6) ? 0 : 1);
      check("frm_vs", vs_s, (vp >= 5 && vp <= 6) ? 0 : 1);
      check("frm_frame_start", fs_s, (k > 0 && (k % 64) == 0) ? 1 : 0);
      if (fs_s === 1'b1) pulses++;
      if (k < 64 && vs_s === 1'b0) begin
        vs_low++;
        if (vs_first < 0) vs_first = k;
      end
      @(negedge vga_clk);
    end
    check("frm_pulses_3frames", pulses, 2);
    check("frm_vs_low_count", vs_low, 16);
    check("frm_vs_first_low", vs_first, 41);
    // Now at the third wrap: pulse high, two frames already counted.
    check("frm_third_pulse", fs_s, 1);
    check("frm_count_3frames", fc_s, FC_EN ? 2 : 0);

    // Run to the 256th frame_start and across the 8-bit wrap.
    repeat (16384 - 192) @(negedge vga_clk);
    check("fc_pulse256", fs_s, 1);
    check("fc_before_wrap", fc_s, FC_EN ? 255 : 0);
    @(negedge vga_clk);
    check("fc_pulse256_end", fs_s, 0);
    check("fc_after_wrap", fc_s, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
